hps_mem_bridge: RTL and testbench



---
 rtl/hps_mem_bridge_pkg.sv | 25 ++
 rtl/hps_mem_bridge_if.sv | 29 ++
 rtl/hps_bridge_regs.sv | 91 +++++++++
 rtl/hps_mem_bridge.sv | 162 ++++++++++++++++
 tb/tb_hps_mem_bridge.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hps_mem_bridge_pkg.sv
// hps_mem_bridge_pkg
// Shared definitions for the HPS memory bridge:
//   - state_e           : bridge FSM states
//   - REGION_BIT        : address bit selecting memory (0) or local registers (1)
//   - OFF_*             : local register word offsets (address[3:2])
//   - ERR_DATA_DEFAULT  : read data returned when a memory access times out
package hps_mem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_REG  = 2'd2,
        ST_ACK  = 2'd3
    } state_e;

    localparam int REGION_BIT = 23;

    localparam logic [1:0] OFF_CTRL          = 2'd0;
    localparam logic [1:0] OFF_MBOX_TO_CPU   = 2'd1;
    localparam logic [1:0] OFF_MBOX_FROM_CPU = 2'd2;
    localparam logic [1:0] OFF_STATUS        = 2'd3;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/hps_mem_bridge_if.sv
// hps_mem_bridge_if
// HPS lightweight Avalon conduit between the HPS (master) and the bridge (slave).
//   avalon_address      24  byte address, bit 23 selects memory/registers
//   avalon_byte_enable   4  byte lanes
//   avalon_read/write    1  request levels, held until acknowledge
//   avalon_write_data   32  write data
//   avalon_acknowledge   1  one-cycle completion pulse
//   avalon_read_data    32  valid only while acknowledge is high
interface hps_mem_bridge_if;
    logic [23:0] avalon_address;
    logic [3:0]  avalon_byte_enable;
    logic        avalon_read;
    logic        avalon_write;
    logic [31:0] avalon_write_data;
    logic        avalon_acknowledge;
    logic [31:0] avalon_read_data;

    modport master (
        output avalon_address, avalon_byte_enable, avalon_read, avalon_write,
               avalon_write_data,
        input  avalon_acknowledge, avalon_read_data
    );

    modport slave (
        input  avalon_address, avalon_byte_enable, avalon_read, avalon_write,
               avalon_write_data,
        output avalon_acknowledge, avalon_read_data
    );
endinterface

// File: rtl/hps_bridge_regs.sv
// hps_bridge_regs
// Local register file of the HPS bridge: CTRL (cpu_hold), HPS->CPU mailbox,
// CPU->HPS mailbox (read-only) and STATUS (sticky timeout W1C, hold mirror).
// Ports:
//   clock, resetn        clock, synchronous active-low reset
//   access_i             one-cycle register access strobe
//   write_i              access is a write
//   offset_ok_i          address[22:4] is zero (decoded register window)
//   offset_i             word offset address[3:2]
//   be_i, wdata_i        byte enables and write data
//   timeout_set_i        sets the sticky STATUS.timeout bit
//   mbox_from_cpu_i      CPU->HPS mailbox value
//   rdata_o              combinational read data for the addressed register
//   cpu_hold_o           CTRL[0]
//   mbox_to_cpu_o        HPS->CPU mailbox
module hps_bridge_regs
    import hps_mem_bridge_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  logic        access_i,
    input  logic        write_i,
    input  logic        offset_ok_i,
    input  logic [1:0]  offset_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    input  logic        timeout_set_i,
    input  logic [31:0] mbox_from_cpu_i,
    output logic [31:0] rdata_o,
    output logic        cpu_hold_o,
    output logic [31:0] mbox_to_cpu_o
);
    logic        hold_q, hold_d;
    logic [31:0] mbox_q, mbox_d;
    logic        timeout_q, timeout_d;
    logic        wr_en;

    assign wr_en = access_i && write_i && offset_ok_i;

    always_comb begin
        hold_d    = hold_q;
        mbox_d    = mbox_q;
        timeout_d = timeout_q;
        if (wr_en) begin
            case (offset_i)
                OFF_CTRL: begin
                    if (be_i[0]) hold_d = wdata_i[0];
                end
                OFF_MBOX_TO_CPU: begin
                    for (int i = 0; i < 4; i++) begin
                        if (be_i[i]) mbox_d[8*i +: 8] = wdata_i[8*i +: 8];
                    end
                end
                OFF_STATUS: begin
                    if (be_i[0] && wdata_i[0]) timeout_d = 1'b0;
                end
                default: ;
            endcase
        end
        // A new timeout event outranks a concurrent clear.
        if (timeout_set_i) timeout_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            hold_q    <= 1'b0;
            mbox_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            mbox_q    <= mbox_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (offset_ok_i) begin
            case (offset_i)
                OFF_CTRL:          rdata_o = {31'b0, hold_q};
                OFF_MBOX_TO_CPU:   rdata_o = mbox_q;
                OFF_MBOX_FROM_CPU: rdata_o = mbox_from_cpu_i;
                OFF_STATUS:        rdata_o = {30'b0, hold_q, timeout_q};
                default:           rdata_o = '0;
            endcase
        end
    end

    assign cpu_hold_o    = hold_q;
    assign mbox_to_cpu_o = mbox_q;
endmodule

// File: rtl/hps_mem_bridge.sv
// hps_mem_bridge
// Slave bridge from the HPS Avalon conduit to the data memory and local
// control registers. One acknowledge pulse per transfer.
// Optional feature macro: HPS_BRIDGE_TIMEOUT_EN (memory wait timeout).
// Ports:
//   clock, resetn                 clock, synchronous active-low reset
//   avl                           Avalon conduit (slave modport)
//   mem_addr/be/wdata, mem_re/we  memory request, stable for the whole MEM phase
//   mem_rdata, mem_ready          memory response
//   cpu_hold                      CTRL[0], stalls the CPU
//   mbox_to_cpu, mbox_from_cpu    mailboxes
module hps_mem_bridge
    import hps_mem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic            clock,
    input  logic            resetn,
    hps_mem_bridge_if.slave avl,
    output logic [20:0]     mem_addr,
    output logic [3:0]      mem_be,
    output logic [31:0]     mem_wdata,
    output logic            mem_re,
    output logic            mem_we,
    input  logic [31:0]     mem_rdata,
    input  logic            mem_ready,
    output logic            cpu_hold,
    output logic [31:0]     mbox_to_cpu,
    input  logic [31:0]     mbox_from_cpu
);
    state_e      state_q, state_d;
    logic [20:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        reg_access;
    logic        timeout_set;
    logic        offset_ok;
    logic [31:0] reg_rdata;
    logic        unused_addr;

`ifdef HPS_BRIDGE_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt_q, wait_cnt_d;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES == 0) ^ (^ERR_DATA);
`endif

    assign unused_addr = ^avl.avalon_address[1:0];
    assign offset_ok   = (avl.avalon_address[22:4] == '0);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        is_wr_d     = is_wr_q;
        rdata_d     = rdata_q;
        reg_access  = 1'b0;
        timeout_set = 1'b0;
`ifdef HPS_BRIDGE_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (avl.avalon_write || avl.avalon_read) begin
                    // Write wins when both request levels are high.
                    is_wr_d = avl.avalon_write;
                    if (avl.avalon_address[REGION_BIT]) begin
                        state_d = ST_REG;
                    end else begin
                        addr_d  = avl.avalon_address[22:2];
                        be_d    = avl.avalon_byte_enable;
                        wdata_d = avl.avalon_write_data;
                        state_d = ST_MEM;
`ifdef HPS_BRIDGE_TIMEOUT_EN
                        wait_cnt_d = '0;
`endif
                    end
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    rdata_d = is_wr_q ? '0 : mem_rdata;
                    state_d = ST_ACK;
                end
`ifdef HPS_BRIDGE_TIMEOUT_EN
                else if (wait_cnt_q == TIMEOUT_LAST) begin
                    rdata_d     = ERR_DATA;
                    timeout_set = 1'b1;
                    state_d     = ST_ACK;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
`endif
            end
            ST_REG: begin
                reg_access = 1'b1;
                rdata_d    = is_wr_q ? '0 : reg_rdata;
                state_d    = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef HPS_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (!resetn) wait_cnt_q <= '0;
        else         wait_cnt_q <= wait_cnt_d;
    end
`endif

    hps_bridge_regs u_regs (
        .clock           (clock),
        .resetn          (resetn),
        .access_i        (reg_access),
        .write_i         (is_wr_q),
        .offset_ok_i     (offset_ok),
        .offset_i        (avl.avalon_address[3:2]),
        .be_i            (avl.avalon_byte_enable),
        .wdata_i         (avl.avalon_write_data),
        .timeout_set_i   (timeout_set),
        .mbox_from_cpu_i (mbox_from_cpu),
        .rdata_o         (reg_rdata),
        .cpu_hold_o      (cpu_hold),
        .mbox_to_cpu_o   (mbox_to_cpu)
    );

    // Strobes are decoded from the state so they can never outlive MEM.
    assign mem_re    = (state_q == ST_MEM) && !is_wr_q;
    assign mem_we    = (state_q == ST_MEM) &&  is_wr_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

    assign avl.avalon_acknowledge = (state_q == ST_ACK);
    assign avl.avalon_read_data   = (state_q == ST_ACK) ? rdata_q : '0;
endmodule

// File: tb/tb_hps_mem_bridge.sv
module tb_hps_mem_bridge;
    logic        clock;
    logic        resetn;
    logic [20:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        cpu_hold;
    logic [31:0] mbox_to_cpu;
    logic [31:0] mbox_from_cpu;

    hps_mem_bridge_if bus ();

    hps_mem_bridge dut (
        .clock         (clock),
        .resetn        (resetn),
        .avl           (bus),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_re        (mem_re),
        .mem_we        (mem_we),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .cpu_hold      (cpu_hold),
        .mbox_to_cpu   (mbox_to_cpu),
        .mbox_from_cpu (mbox_from_cpu)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: ready after mem_delay wait cycles, data derived from address.
    int   mem_delay;
    bit   mem_stuck;
    int   mem_cnt;
    assign mem_ready = (mem_re || mem_we) && !mem_stuck && (mem_cnt == mem_delay);
    assign mem_rdata = {11'h2AB, mem_addr};

    always @(posedge clock) begin
        mem_cnt <= (mem_re || mem_we) ? mem_cnt + 1 : 0;
    end

    int          we_cycles;
    int          overlap_cnt;
    int          ack_cnt;
    logic [20:0] last_waddr;
    logic [31:0] last_wdata;
    logic [3:0]  last_wbe;

    always @(negedge clock) begin
        if (mem_we) we_cycles++;
        if (mem_re && mem_we) overlap_cnt++;
        if (bus.avalon_acknowledge) ack_cnt++;
        if (mem_we && mem_ready) begin
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
            last_wbe   = mem_be;
        end
    end

    int errors;
    int checks;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One complete HPS transfer; lat counts edges from request to visible acknowledge.
    task automatic xfer(input bit rd, input bit wr, input logic [23:0] a, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rdat, output int lat);
        bus.avalon_address     = a;
        bus.avalon_byte_enable = be;
        bus.avalon_write_data  = wd;
        bus.avalon_read        = rd;
        bus.avalon_write       = wr;
        lat  = 0;
        rdat = '0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clock);
            #1;
            if (bus.avalon_acknowledge) begin
                lat  = i;
                rdat = bus.avalon_read_data;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL ack_wait: no acknowledge for addr 0x%06h within 400 cycles", a);
        end
        @(posedge clock);
        #1;
        bus.avalon_read  = 1'b0;
        bus.avalon_write = 1'b0;
        $display("xfer rd=%0d wr=%0d addr=0x%06h be=%b wd=0x%08h -> rdata=0x%08h lat=%0d",
                 rd, wr, a, be, wd, rdat, lat);
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [23:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        int          delay;
        logic [31:0] exp_rd;
        int          exp_lat;
        logic        exp_hold;
        logic [31:0] exp_mbox;
    } vec_t;

    vec_t vecs[18];

    initial begin
        logic [31:0] rdat;
        int          lat;
        int          a0;
        int          w0;

        vecs[0]  = '{0, 1, 24'h800004, 4'hF, 32'h12345678, 0, 32'h0,        2, 1'b0, 32'h12345678};
        vecs[1]  = '{1, 0, 24'h800004, 4'hF, 32'h0,        0, 32'h12345678, 2, 1'b0, 32'h12345678};
        vecs[2]  = '{0, 1, 24'h800000, 4'h1, 32'h1,        0, 32'h0,        2, 1'b1, 32'h12345678};
        vecs[3]  = '{1, 0, 24'h800008, 4'hF, 32'h0,        0, 32'hCAFEF00D, 2, 1'b1, 32'h12345678};
        vecs[4]  = '{1, 0, 24'h80000C, 4'hF, 32'h0,        0, 32'h2,        2, 1'b1, 32'h12345678};
        vecs[5]  = '{1, 0, 24'h800000, 4'hF, 32'h0,        0, 32'h1,        2, 1'b1, 32'h12345678};
        vecs[6]  = '{0, 1, 24'h800004, 4'h5, 32'hAABBCCDD, 0, 32'h0,        2, 1'b1, 32'h12BB56DD};
        vecs[7]  = '{1, 0, 24'h800004, 4'hF, 32'h0,        0, 32'h12BB56DD, 2, 1'b1, 32'h12BB56DD};
        vecs[8]  = '{0, 1, 24'h800014, 4'hF, 32'hFFFFFFFF, 0, 32'h0,        2, 1'b1, 32'h12BB56DD};
        vecs[9]  = '{1, 0, 24'h800014, 4'hF, 32'h0,        0, 32'h0,        2, 1'b1, 32'h12BB56DD};
        vecs[10] = '{1, 1, 24'h800004, 4'hF, 32'h0BADF00D, 0, 32'h0,        2, 1'b1, 32'h0BADF00D};
        vecs[11] = '{0, 1, 24'h800000, 4'hE, 32'h0,        0, 32'h0,        2, 1'b1, 32'h0BADF00D};
        vecs[12] = '{0, 1, 24'h800000, 4'h1, 32'hFFFFFFFE, 0, 32'h0,        2, 1'b0, 32'h0BADF00D};
        vecs[13] = '{1, 0, 24'h80000C, 4'hF, 32'h0,        0, 32'h0,        2, 1'b0, 32'h0BADF00D};
        vecs[14] = '{1, 0, 24'h000100, 4'hF, 32'h0,        0, 32'h55600040, 2, 1'b0, 32'h0BADF00D};
        vecs[15] = '{0, 1, 24'h000200, 4'hF, 32'h99887766, 1, 32'h0,        3, 1'b0, 32'h0BADF00D};
        vecs[16] = '{1, 0, 24'h7FFFFC, 4'hF, 32'h0,        2, 32'h557FFFFF, 4, 1'b0, 32'h0BADF00D};
        vecs[17] = '{1, 0, 24'h800004, 4'hF, 32'h0,        0, 32'h0BADF00D, 2, 1'b0, 32'h0BADF00D};

        errors = 0;
        checks = 0;
        we_cycles = 0;
        overlap_cnt = 0;
        ack_cnt = 0;
        mem_delay = 0;
        mem_stuck = 1'b0;
        mem_cnt = 0;
        last_waddr = '0;
        last_wdata = '0;
        last_wbe = '0;
        mbox_from_cpu = 32'hCAFEF00D;
        bus.avalon_address = '0;
        bus.avalon_byte_enable = '0;
        bus.avalon_write_data = '0;
        bus.avalon_read = 1'b0;
        bus.avalon_write = 1'b0;

        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_ack", {31'b0, bus.avalon_acknowledge}, 32'h0);
        check("rst_rdata", bus.avalon_read_data, 32'h0);
        check("rst_strobes", {30'b0, mem_re, mem_we}, 32'h0);
        check("rst_mem_req", {7'b0, mem_be, mem_addr} | mem_wdata, 32'h0);
        check("rst_hold", {31'b0, cpu_hold}, 32'h0);
        check("rst_mbox", mbox_to_cpu, 32'h0);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < 18; i++) begin
            mem_delay = vecs[i].delay;
            xfer(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd, rdat, lat);
            check($sformatf("v%0d_rdata", i), rdat, vecs[i].exp_rd);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_hold", i), {31'b0, cpu_hold}, {31'b0, vecs[i].exp_hold});
            check($sformatf("v%0d_mbox", i), mbox_to_cpu, vecs[i].exp_mbox);
        end

        // Memory write with three wait cycles.
        mem_delay = 3;
        a0 = ack_cnt;
        w0 = we_cycles;
        xfer(1'b0, 1'b1, 24'h000010, 4'hF, 32'h11223344, rdat, lat);
        check("mw_lat", 32'(lat), 32'd5);
        check("mw_we_cycles", 32'(we_cycles - w0), 32'd4);
        check("mw_ack_pulses", 32'(ack_cnt - a0), 32'd1);
        check("mw_addr", {11'b0, last_waddr}, 32'd4);
        check("mw_wdata", last_wdata, 32'h11223344);
        check("mw_be", {28'b0, last_wbe}, 32'hF);
        check("mw_rdata", rdat, 32'h0);
        mem_delay = 0;

        // Reset in the middle of a stalled memory read.
        xfer(1'b0, 1'b1, 24'h800000, 4'h1, 32'h1, rdat, lat);
        check("pre_rst_hold", {31'b0, cpu_hold}, 32'h1);
        mem_stuck = 1'b1;
        bus.avalon_address = 24'h000040;
        bus.avalon_byte_enable = 4'hF;
        bus.avalon_read = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("mid_re", {31'b0, mem_re}, 32'h1);
        a0 = ack_cnt;
        resetn = 1'b0;
        @(posedge clock);
        #1;
        bus.avalon_read = 1'b0;
        check("mid_rst_strobes", {30'b0, mem_re, mem_we}, 32'h0);
        check("mid_rst_ack", {31'b0, bus.avalon_acknowledge}, 32'h0);
        check("mid_rst_hold", {31'b0, cpu_hold}, 32'h0);
        check("mid_rst_mbox", mbox_to_cpu, 32'h0);
        check("mid_rst_addr", {11'b0, mem_addr}, 32'h0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        mem_stuck = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("mid_rst_no_ack", 32'(ack_cnt - a0), 32'd0);
        xfer(1'b1, 1'b0, 24'h80000C, 4'hF, 32'h0, rdat, lat);
        check("post_rst_status", rdat, 32'h0);

`ifdef HPS_BRIDGE_TIMEOUT_EN
        mem_stuck = 1'b1;
        xfer(1'b1, 1'b0, 24'h000020, 4'hF, 32'h0, rdat, lat);
        mem_stuck = 1'b0;
        check("to_lat", 32'(lat), 32'd256);
        check("to_rdata", rdat, 32'hDEADBEEF);
        check("to_strobes", {30'b0, mem_re, mem_we}, 32'h0);
        xfer(1'b1, 1'b0, 24'h80000C, 4'hF, 32'h0, rdat, lat);
        check("to_status_set", rdat, 32'h1);
        xfer(1'b0, 1'b1, 24'h80000C, 4'h1, 32'h1, rdat, lat);
        xfer(1'b1, 1'b0, 24'h80000C, 4'hF, 32'h0, rdat, lat);
        check("to_status_clr", rdat, 32'h0);
`endif

        check("strobe_overlap", 32'(overlap_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
